// File: rtl/mips16_pkg.sv
// mips16_pkg: definitions shared by the 16-bit core's support blocks.
//   - imem_ld_state_t : loader FSM state encoding
//   - WORD_W / BYTE_W : instruction word and pin byte widths
//   - OP_*            : 3-bit major opcodes, used when building program images
package mips16_pkg;

    localparam int WORD_W = 16;
    localparam int BYTE_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_HI   = 3'd1,
        ST_LO   = 3'd2,
        ST_CHK  = 3'd3,
        ST_DONE = 3'd4,
        ST_ERR  = 3'd5
    } imem_ld_state_t;

    // Major opcodes live in instruction bits [15:13].
    localparam logic [2:0] OP_ADD  = 3'd0;
    localparam logic [2:0] OP_SUB  = 3'd1;
    localparam logic [2:0] OP_ADDI = 3'd2;
    localparam logic [2:0] OP_LW   = 3'd3;
    localparam logic [2:0] OP_SW   = 3'd4;
    localparam logic [2:0] OP_BEQ  = 3'd5;
    localparam logic [2:0] OP_AND  = 3'd6;
    localparam logic [2:0] OP_OR   = 3'd7;

    // Place an opcode and a 13-bit operand field into one instruction word.
    function automatic logic [WORD_W-1:0] make_insn(input logic [2:0] op,
                                                    input logic [12:0] fields);
        return {op, fields};
    endfunction

endpackage

// File: rtl/pin_sync.sv
// pin_sync: brings an asynchronous pin level into the clk domain and turns
// each rising edge into a one-cycle pulse.
//   clk    in  clock
//   rst_n  in  asynchronous active-low reset
//   pin    in  raw pin level
//   pulse  out one-cycle pulse, high STAGES cycles after the pin rises;
//              the consumer captures on the following clock edge
module pin_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pin,
    output logic pulse
);

    logic [STAGES-1:0] sync_q;
    logic              prev_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], pin};
            prev_q <= sync_q[STAGES-1];
        end
    end

    // Edge detect on the synchronized level; prev_q is the extra flop that
    // makes the pulse last exactly one cycle.
    assign pulse = sync_q[STAGES-1] & ~prev_q;

endmodule

// File: rtl/imem_loader.sv
// imem_loader: byte-serial program loader and instruction RAM for the
// 16-bit core. Pin bytes (high byte first, word 0 first) are packed into
// 16-bit words and written into a NUM_WORDS-deep flop RAM. The core fetches
// combinationally through rd_addr/rd_data and is held in reset until a full
// image has been loaded (cpu_run).
//
// Compile-time option: IMEM_LOADER_CHECKSUM_EN -- adds a trailing checksum
// byte (XOR of all image bytes); a mismatch parks the FSM in ERR.
//
// Ports:
//   clk        in   clock
//   rst_n      in   asynchronous active-low reset
//   load_start in   pin level, rising edge starts/restarts a load
//   byte_stb   in   pin level, rising edge marks byte_data valid
//   byte_data  in   [7:0] pin byte
//   rd_addr    in   [15:0] fetch byte address (PC); bit 0 ignored
//   rd_data    out  [15:0] instruction at rd_addr, 0 when out of range
//   cpu_run    out  core released from reset (image complete)
//   busy       out  load in progress
//   err        out  last load failed its checksum (0 without checksum)
//   word_cnt   out  [3:0] next word index to be written
//
// Byte transfer protocol: there is no ready; a byte is offered by a rising
// edge on byte_stb and accepted unconditionally in HI/LO/CHK, ignored in all
// other states. byte_data must be held across the synchronizer latency.
module imem_loader
    import mips16_pkg::*;
#(
    parameter int NUM_WORDS   = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load_start,
    input  logic        byte_stb,
    input  logic [7:0]  byte_data,
    input  logic [15:0] rd_addr,
    output logic [15:0] rd_data,
    output logic        cpu_run,
    output logic        busy,
    output logic        err,
    output logic [3:0]  word_cnt
);

    localparam int IDX_W = $clog2(NUM_WORDS);

    localparam logic [2:0] S_IDLE = ST_IDLE;
    localparam logic [2:0] S_HI   = ST_HI;
    localparam logic [2:0] S_LO   = ST_LO;
    localparam logic [2:0] S_DONE = ST_DONE;
`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam logic [2:0] S_CHK  = ST_CHK;
    localparam logic [2:0] S_ERR  = ST_ERR;
`endif

    localparam logic [3:0]  LAST_WORD = 4'(NUM_WORDS - 1);
    localparam logic [15:0] ADDR_LIM  = 16'(2 * NUM_WORDS);

    // FSM state; kept as a plain named signal so checkers can bind to it.
    logic [2:0]        state;
    logic [BYTE_W-1:0] hi_reg;
    logic [WORD_W-1:0] mem [NUM_WORDS];
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [BYTE_W-1:0] chk;
`endif

    logic start_p;
    logic stb_p;

    pin_sync #(.STAGES(SYNC_STAGES)) u_sync_start (
        .clk   (clk),
        .rst_n (rst_n),
        .pin   (load_start),
        .pulse (start_p)
    );

    pin_sync #(.STAGES(SYNC_STAGES)) u_sync_stb (
        .clk   (clk),
        .rst_n (rst_n),
        .pin   (byte_stb),
        .pulse (stb_p)
    );

    // Only the low-byte capture writes the RAM, so no half word is ever stored.
    logic               wr_en;
    logic [IDX_W-1:0]   wr_idx;
    assign wr_en  = stb_p && !start_p && (state == S_LO);
    assign wr_idx = word_cnt[IDX_W-1:0];

    // Control FSM. start_p has priority over everything, including a byte
    // arriving in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            word_cnt <= 4'd0;
            hi_reg   <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            chk      <= '0;
`endif
        end else if (start_p) begin
            state    <= S_HI;
            word_cnt <= 4'd0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            chk      <= '0;
`endif
        end else if (stb_p) begin
            case (state)
                S_HI: begin
                    hi_reg <= byte_data;
`ifdef IMEM_LOADER_CHECKSUM_EN
                    chk    <= chk ^ byte_data;
`endif
                    state  <= S_LO;
                end
                S_LO: begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                    chk <= chk ^ byte_data;
`endif
                    if (word_cnt == LAST_WORD) begin
                        word_cnt <= 4'd0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                        state    <= S_CHK;
`else
                        state    <= S_DONE;
`endif
                    end else begin
                        word_cnt <= word_cnt + 4'd1;
                        state    <= S_HI;
                    end
                end
`ifdef IMEM_LOADER_CHECKSUM_EN
                S_CHK: begin
                    state <= (byte_data == chk) ? S_DONE : S_ERR;
                end
`endif
                default: begin
                    // IDLE, DONE, ERR: strobes are ignored.
                    state <= state;
                end
            endcase
        end
    end

    // Instruction RAM. Contents survive a restart; only reset clears them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_WORDS; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_en) begin
            mem[wr_idx] <= {hi_reg, byte_data};
        end
    end

    // Fetch port: PC is a byte address, word index drops bit 0. Anything at or
    // beyond the image size reads as zero rather than aliasing.
    logic [IDX_W-1:0] rd_idx;
    logic             rd_in_range;
    assign rd_idx      = rd_addr[IDX_W:1];
    assign rd_in_range = (rd_addr < ADDR_LIM);
    assign rd_data     = rd_in_range ? mem[rd_idx] : '0;

    assign cpu_run = (state == S_DONE);

`ifdef IMEM_LOADER_CHECKSUM_EN
    assign busy = (state == S_HI) || (state == S_LO) || (state == S_CHK);
    assign err  = (state == S_ERR);
`else
    assign busy = (state == S_HI) || (state == S_LO);
    assign err  = 1'b0;
`endif

endmodule

// File: tb/tb_imem_loader.sv
module tb_imem_loader;
    import mips16_pkg::*;

    localparam int NW   = 16;
    localparam int SYNC = 2;
    localparam int NB   = 2 * NW;
`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam bit CHK_EN = 1'b1;
`else
    localparam bit CHK_EN = 1'b0;
`endif

    // ---------------- clock / reset ----------------
    logic        clk = 1'b0;
    logic        rst_n;
    logic        load_start;
    logic        byte_stb;
    logic [7:0]  byte_data;
    logic [15:0] rd_addr;
    logic [15:0] rd_data;
    logic        cpu_run;
    logic        busy;
    logic        err;
    logic [3:0]  word_cnt;

    always #5 clk = ~clk;

    imem_loader #(.NUM_WORDS(NW), .SYNC_STAGES(SYNC)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_start (load_start),
        .byte_stb   (byte_stb),
        .byte_data  (byte_data),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .cpu_run    (cpu_run),
        .busy       (busy),
        .err        (err),
        .word_cnt   (word_cnt)
    );

    // ---------------- scoreboard bookkeeping ----------------
    int tests  = 0;
    int failed = 0;
    bit chk_on = 1'b0;
    bit rd_manual = 1'b0;
    logic [15:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // A load is a count of accepted bytes; words and flags follow from it.
    logic [15:0] m_mem [NW];
    int          m_nbytes;
    bit          m_active;
    bit          m_done;
    bit          m_err;
    logic [7:0]  m_pend;
    logic [7:0]  m_xor;

    task automatic model_reset();
        for (int i = 0; i < NW; i++) m_mem[i] = 16'h0000;
        m_nbytes = 0; m_active = 0; m_done = 0; m_err = 0;
        m_pend = 8'h00; m_xor = 8'h00;
    endtask

    task automatic model_start();
        m_nbytes = 0; m_active = 1; m_done = 0; m_err = 0; m_xor = 8'h00;
    endtask

    task automatic model_byte(input logic [7:0] b);
        if (!m_active) return;
        if (m_nbytes < NB) begin
            m_xor ^= b;
            if (m_nbytes % 2 == 1) m_mem[m_nbytes / 2] = {m_pend, b};
            else m_pend = b;
            m_nbytes++;
            if (m_nbytes == NB && !CHK_EN) begin
                m_active = 0; m_done = 1;
            end
        end else begin
            m_active = 0;
            if (b == m_xor) m_done = 1;
            else m_err = 1;
        end
    endtask

    function automatic logic [15:0] model_read(input logic [15:0] a);
        if (a >= 16'(NB)) return 16'h0000;
        return m_mem[a / 2];
    endfunction

    // ---------------- per-cycle compare process ----------------
    always @(negedge clk) begin
        if (chk_on) begin
            check("cpu_run", 32'(cpu_run), 32'(m_done));
            check("busy", 32'(busy), 32'(m_active));
            check("err", 32'(err), 32'(m_err));
            check("word_cnt", 32'(word_cnt), 32'((m_nbytes / 2) % NW));
            check("rd_data", 32'(rd_data), 32'(model_read(rd_addr)));
            if (!rd_manual) begin
                if ($urandom_range(0, 9) < 8) rd_addr = 16'($urandom_range(0, NB + 3));
                else rd_addr = 16'($urandom);
            end
        end
    end

    // ---------------- driver tasks ----------------
    // Pulse reaches the FSM SYNC cycles after the pin edge; capture is on the
    // next edge, so the model updates SYNC+1 posedges after the drive.
    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        byte_data = b;
        byte_stb  = 1'b1;
        repeat (SYNC + 1) @(posedge clk);
        model_byte(b);
        repeat (3) @(negedge clk);
        byte_stb = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic send_start();
        @(negedge clk);
        load_start = 1'b1;
        repeat (SYNC + 1) @(posedge clk);
        model_start();
        repeat (3) @(negedge clk);
        load_start = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic send_start_with_byte(input logic [7:0] b);
        @(negedge clk);
        byte_data  = b;
        byte_stb   = 1'b1;
        load_start = 1'b1;
        repeat (SYNC + 1) @(posedge clk);
        model_start();
        repeat (3) @(negedge clk);
        byte_stb   = 1'b0;
        load_start = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic rd_check(input string name, input logic [15:0] a, input logic [15:0] exp);
        @(posedge clk);
        #2;
        rd_manual = 1'b1;
        rd_addr   = a;
        #1;
        check(name, 32'(rd_data), 32'(exp));
        rd_manual = 1'b0;
    endtask

    // Send a full image; checksum byte appended when compiled in.
    task automatic load_image(input logic [15:0] img [NW], input bit good_chk);
        logic [7:0] x;
        x = 8'h00;
        send_start();
        for (int i = 0; i < NW; i++) begin
            send_byte(img[i][15:8]);
            send_byte(img[i][7:0]);
            x ^= img[i][15:8] ^ img[i][7:0];
        end
        if (CHK_EN) send_byte(good_chk ? x : (x ^ 8'h5A));
    endtask

    // ---------------- main sequence ----------------
    logic [15:0] img [NW];

    initial begin
        rst_n = 1'b0; load_start = 1'b0; byte_stb = 1'b0;
        byte_data = 8'h00; rd_addr = 16'h0000;
        model_reset();
        repeat (3) @(negedge clk);

        // Reset state, literal expectations.
        check("rst_cpu_run", 32'(cpu_run), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_word_cnt", 32'(word_cnt), 32'd0);
        for (int a = 0; a <= 30; a++) rd_check("rst_rd", 16'(a), 16'h0000);

        @(negedge clk);
        rst_n  = 1'b1;
        chk_on = 1'b1;

        // Pattern image 0x0123, 0x1234, 0x2345, ...
        for (int i = 0; i < NW; i++) begin
            img[i] = {8'(8'h01 + 8'h11 * i), 8'(8'h23 + 8'h11 * i)};
            exp_q.push_back(img[i]);
        end
        load_image(img, 1'b1);
        rd_check("pat_rd0", 16'd0, 16'h0123);
        rd_check("pat_rd2", 16'd2, 16'h1234);
        rd_check("pat_rd3", 16'd3, 16'h1234);
        rd_check("pat_rd32", 16'd32, 16'h0000);
        rd_check("pat_rdFFFE", 16'hFFFE, 16'h0000);
        check("pat_cpu_run", 32'(cpu_run), 32'd1);
        check("pat_busy", 32'(busy), 32'd0);
        for (int i = 0; i < NW; i++) begin
            logic [15:0] e;
            e = exp_q.pop_front();
            rd_check("pat_word", 16'(2 * i), e);
        end

        // Strobes in DONE are ignored.
        for (int i = 0; i < 3; i++) send_byte(8'($urandom));
        rd_check("done_ignore_rd0", 16'd0, 16'h0123);
        check("done_ignore_wc", 32'(word_cnt), 32'd0);

        // Restart after 5 bytes.
        send_start();
        send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC);
        send_byte(8'hDD); send_byte(8'hEE);
        send_start();
        check("restart_wc", 32'(word_cnt), 32'd0);
        check("restart_state", 32'(dut.state), 32'(ST_HI));
        rd_check("restart_w0_kept", 16'd0, 16'hAABB);
        send_byte(8'h11); send_byte(8'h22);
        rd_check("restart_w0_new", 16'd0, 16'h1122);
        rd_check("restart_w1_kept", 16'd2, 16'hCCDD);
        send_byte(8'h33);

        // Simultaneous start and strobe: start wins, byte dropped.
        send_start_with_byte(8'h77);
        send_byte(8'h44); send_byte(8'h55);
        rd_check("simul_w0", 16'd0, 16'h4455);

`ifdef IMEM_LOADER_CHECKSUM_EN
        // Bad checksum, then recovery through load_start.
        for (int i = 0; i < NW; i++) img[i] = 16'($urandom);
        load_image(img, 1'b0);
        check("chk_bad_err", 32'(err), 32'd1);
        check("chk_bad_run", 32'(cpu_run), 32'd0);
        send_start();
        check("chk_clear_err", 32'(err), 32'd0);
        for (int i = 0; i < NB; i++) send_byte(8'($urandom));
        send_byte(m_xor);
        check("chk_good_run", 32'(cpu_run), 32'd1);
`endif

        // Randomized loads, some with opcode-shaped words, some aborted.
        for (int n = 0; n < 4; n++) begin
            for (int i = 0; i < NW; i++)
                img[i] = (n % 2 == 0) ? make_insn(3'($urandom_range(0, 7)), 13'($urandom))
                                      : 16'($urandom);
            if ($urandom_range(0, 2) == 0) begin
                send_start();
                for (int i = 0; i < int'($urandom_range(1, 12)); i++) send_byte(8'($urandom));
            end
            load_image(img, ($urandom_range(0, 3) != 0));
        end

        // Reset in the middle of a load.
        send_start();
        for (int i = 0; i < 20; i++) send_byte(8'($urandom));
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check("mid_rst_cpu_run", 32'(cpu_run), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_err", 32'(err), 32'd0);
        check("mid_rst_wc", 32'(word_cnt), 32'd0);
        for (int a = 0; a <= 30; a += 2) rd_check("mid_rst_rd", 16'(a), 16'h0000);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        chk_on = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    // Watchdog bounds the whole run.
    initial begin
        #2000000;
        failed++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $fatal(1, "timeout");
    end

endmodule
